// File: rtl/ecc_pkg.sv
// Shared types and field helpers for the affine point adder and the
// scalar-multiplication controller that drives it.
package ecc_pkg;

  localparam int unsigned ECC_MAX_W = 256;

  localparam logic [127:0] ECC_P_DEFAULT = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] ECC_A_DEFAULT = 128'd1;

  typedef logic [ECC_MAX_W-1:0] ecc_word_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK,
    ST_SQX,
    ST_DIFF,
    ST_INV,
    ST_MUL_L,
    ST_MUL_SQ,
    ST_X3,
    ST_MUL_Y,
    ST_Y3,
    ST_DONE
  } ecc_state_e;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_FIN
  } mm_state_e;

  // Operands must already be reduced (< p); callers zero-extend to ECC_MAX_W.
  function automatic ecc_word_t mod_add(input ecc_word_t a, input ecc_word_t b,
                                        input ecc_word_t p);
    logic [ECC_MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[ECC_MAX_W-1:0];
  endfunction

  function automatic ecc_word_t mod_sub(input ecc_word_t a, input ecc_word_t b,
                                        input ecc_word_t p);
    return (a >= b) ? (a - b) : (a + (p - b));
  endfunction

endpackage

// File: rtl/ecc_point_add_if.sv
// Point-operation request/response bundle between the scalar-multiplication
// controller (master) and the point adder (slave).
interface ecc_point_add_if #(
  parameter int unsigned DATA_WIDTH = 128
);

  logic [DATA_WIDTH-1:0] Px;
  logic [DATA_WIDTH-1:0] Py;
  logic [DATA_WIDTH-1:0] Qx;
  logic [DATA_WIDTH-1:0] Qy;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] Rx;
  logic [DATA_WIDTH-1:0] Ry;
  logic                  out_valid;

  modport master (
    output Px, Py, Qx, Qy, in_valid,
    input  Rx, Ry, out_valid
  );

  modport slave (
    input  Px, Py, Qx, Qy, in_valid,
    output Rx, Ry, out_valid
  );

endinterface

// File: rtl/ecc_mod_mul.sv
// Bit-serial MSB-first interleaved modular multiplier, r = a*b mod P_MOD.
// DATA_WIDTH+2 cycles from start pulse to done pulse; r_o holds until next start.
module ecc_mod_mul
  import ecc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 128,
  parameter logic [DATA_WIDTH-1:0] P_MOD      = DATA_WIDTH'(ECC_P_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] r_o
);

  localparam int unsigned   W    = DATA_WIDTH + 2;
  localparam int unsigned   CW   = $clog2(DATA_WIDTH);
  localparam logic [W-1:0]  PW   = W'(P_MOD);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  mm_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          acc_q, acc_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;

  logic [W-1:0] sum_c, red1_c, red2_c;

  // acc < p and a < p, so 2*acc + a < 3p: two conditional subtractions suffice.
  always_comb begin
    sum_c  = (acc_q << 1) + (b_q[DATA_WIDTH-1] ? a_q : '0);
    red1_c = (sum_c >= PW) ? (sum_c - PW) : sum_c;
    red2_c = (red1_c >= PW) ? (red1_c - PW) : red1_c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    r_d     = r_q;
    case (state_q)
      MM_IDLE: begin
        if (start_i) begin
          a_d     = W'(a_i);
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MM_RUN;
        end
      end
      MM_RUN: begin
        acc_d = red2_c;
        b_d   = b_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = MM_FIN;
      end
      MM_FIN: begin
        r_d     = acc_q[DATA_WIDTH-1:0];
        done_d  = 1'b1;
        state_d = MM_IDLE;
      end
      default: state_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MM_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
    r_q   <= r_d;
  end

  assign done_o = done_q;
  assign r_o    = r_q;

endmodule

// File: rtl/ecc_point_add.sv
// Affine point add/double over GF(P_MOD) with (0,0) as infinity. One shared
// serial multiplier and an inline binary extended-Euclid inverter.
module ecc_point_add
  import ecc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 128,
  parameter logic [DATA_WIDTH-1:0] P_MOD      = DATA_WIDTH'(ECC_P_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] A_COEF     = DATA_WIDTH'(ECC_A_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  ecc_point_add_if.slave   io
);

  typedef logic [DATA_WIDTH-1:0] fe_t;

  function automatic fe_t madd(input fe_t a, input fe_t b);
    return fe_t'(mod_add(ecc_word_t'(a), ecc_word_t'(b), ecc_word_t'(P_MOD)));
  endfunction

  function automatic fe_t msub(input fe_t a, input fe_t b);
    return fe_t'(mod_sub(ecc_word_t'(a), ecc_word_t'(b), ecc_word_t'(P_MOD)));
  endfunction

  function automatic fe_t mhalf(input fe_t x);
    logic [DATA_WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, P_MOD}) : {1'b0, x};
    return fe_t'(s >> 1);
  endfunction

  ecc_state_e state_q, state_d;
  fe_t        px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
  logic       dbl_q, dbl_d;
  fe_t        num_q, num_d;
  fe_t        u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
  fe_t        lam_q, lam_d, x3_q, x3_d;
  fe_t        resx_q, resx_d, resy_q, resy_d;
  fe_t        rx_q, rx_d, ry_q, ry_d;
  logic       ov_q, ov_d;

  logic mul_start, mul_done;
  fe_t  mul_a, mul_b, mul_r;
  fe_t  num_c, den_c, x3_c, inv_c;

  ecc_mod_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .P_MOD     (P_MOD)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(mul_start),
    .a_i    (mul_a),
    .b_i    (mul_b),
    .done_o (mul_done),
    .r_o    (mul_r)
  );

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    dbl_d     = dbl_q;
    num_d     = num_q;
    u_d       = u_q;
    v_d       = v_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    lam_d     = lam_q;
    x3_d      = x3_q;
    resx_d    = resx_q;
    resy_d    = resy_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    ov_d      = 1'b0;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    num_c     = '0;
    den_c     = '0;
    x3_c      = '0;
    inv_c     = '0;
    case (state_q)
      // The pulse cycle itself does not accept a request.
      ST_IDLE: begin
        if (io.in_valid && !ov_q) begin
          px_d    = io.Px;
          py_d    = io.Py;
          qx_d    = io.Qx;
          qy_d    = io.Qy;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (px_q == '0 && py_q == '0) begin
          resx_d  = qx_q;
          resy_d  = qy_q;
          state_d = ST_DONE;
        end else if (qx_q == '0 && qy_q == '0) begin
          resx_d  = px_q;
          resy_d  = py_q;
          state_d = ST_DONE;
        end else if (px_q == qx_q && madd(py_q, qy_q) == '0) begin
          resx_d  = '0;
          resy_d  = '0;
          state_d = ST_DONE;
        end else if (px_q == qx_q && py_q == qy_q) begin
          dbl_d     = 1'b1;
          mul_start = 1'b1;
          mul_a     = px_q;
          mul_b     = px_q;
          state_d   = ST_SQX;
        end else begin
          dbl_d   = 1'b0;
          state_d = ST_DIFF;
        end
      end
      ST_SQX: begin
        if (mul_done) state_d = ST_DIFF;
      end
      ST_DIFF: begin
        if (dbl_q) begin
          num_c = madd(madd(madd(mul_r, mul_r), mul_r), A_COEF);
          den_c = madd(py_q, py_q);
        end else begin
          num_c = msub(qy_q, py_q);
          den_c = msub(qx_q, px_q);
        end
        num_d   = num_c;
        u_d     = den_c;
        v_d     = P_MOD;
        x1_d    = fe_t'(1);
        x2_d    = '0;
        state_d = ST_INV;
      end
      // Invariants x1*den == u, x2*den == v (mod p). u == 0 only arises from
      // operands off any common curve; exiting keeps the FSM from stalling.
      ST_INV: begin
        if (u_q == fe_t'(1) || v_q == fe_t'(1) || u_q == '0) begin
          inv_c     = (u_q == fe_t'(1)) ? x1_q : x2_q;
          mul_start = 1'b1;
          mul_a     = num_q;
          mul_b     = inv_c;
          state_d   = ST_MUL_L;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = mhalf(x1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = mhalf(x2_q);
        end else if (u_q > v_q) begin
          u_d  = (u_q - v_q) >> 1;
          x1_d = mhalf(msub(x1_q, x2_q));
        end else begin
          v_d  = (v_q - u_q) >> 1;
          x2_d = mhalf(msub(x2_q, x1_q));
        end
      end
      ST_MUL_L: begin
        if (mul_done) begin
          lam_d     = mul_r;
          mul_start = 1'b1;
          mul_a     = mul_r;
          mul_b     = mul_r;
          state_d   = ST_MUL_SQ;
        end
      end
      ST_MUL_SQ: begin
        if (mul_done) state_d = ST_X3;
      end
      ST_X3: begin
        x3_c      = msub(msub(mul_r, px_q), qx_q);
        x3_d      = x3_c;
        mul_start = 1'b1;
        mul_a     = lam_q;
        mul_b     = msub(px_q, x3_c);
        state_d   = ST_MUL_Y;
      end
      ST_MUL_Y: begin
        if (mul_done) state_d = ST_Y3;
      end
      ST_Y3: begin
        resx_d  = x3_q;
        resy_d  = msub(mul_r, py_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rx_d    = resx_q;
        ry_d    = resy_q;
        ov_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rx_q    <= '0;
      ry_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      ov_q    <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    px_q   <= px_d;
    py_q   <= py_d;
    qx_q   <= qx_d;
    qy_q   <= qy_d;
    dbl_q  <= dbl_d;
    num_q  <= num_d;
    u_q    <= u_d;
    v_q    <= v_d;
    x1_q   <= x1_d;
    x2_q   <= x2_d;
    lam_q  <= lam_d;
    x3_q   <= x3_d;
    resx_q <= resx_d;
    resy_q <= resy_d;
  end

  assign io.Rx        = rx_q;
  assign io.Ry        = ry_q;
  assign io.out_valid = ov_q;

endmodule

// File: tb/tb_ecc_point_add.sv
// Bench for ecc_point_add: directed 8-bit curve vectors and corner sequences,
// plus random points at 8 and 128 bits against a Fermat-inverse field model.
module tb_ecc_point_add;

  typedef logic [255:0] big_t;

  localparam big_t P8   = 256'd97;
  localparam big_t A8   = 256'd2;
  localparam big_t P128 = 256'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam big_t A128 = 256'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ecc_point_add_if #(.DATA_WIDTH(8))   if8 ();
  ecc_point_add_if #(.DATA_WIDTH(128)) if128 ();

  ecc_point_add #(
    .DATA_WIDTH(8),
    .P_MOD     (8'd97),
    .A_COEF    (8'd2)
  ) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (if8.slave)
  );

  ecc_point_add #(
    .DATA_WIDTH(128)
  ) dut128 (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (if128.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input big_t act, input big_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference field arithmetic: plain integer ops, inverse via a^(p-2).
  function automatic big_t fadd(input big_t a, input big_t b, input big_t p);
    return (a + b) % p;
  endfunction
  function automatic big_t fsub(input big_t a, input big_t b, input big_t p);
    return (a + p - b) % p;
  endfunction
  function automatic big_t fmul(input big_t a, input big_t b, input big_t p);
    return (a * b) % p;
  endfunction
  function automatic big_t finv(input big_t a, input big_t p);
    big_t r, e;
    r = 1;
    e = p - 2;
    for (int i = 255; i >= 0; i--) begin
      r = fmul(r, r, p);
      if (e[i]) r = fmul(r, a, p);
    end
    return r;
  endfunction

  task automatic ref_add(input big_t px, input big_t py, input big_t qx, input big_t qy,
                         input big_t p, input big_t a, output big_t rx, output big_t ry);
    big_t lam;
    if (px == 0 && py == 0) begin
      rx = qx; ry = qy;
    end else if (qx == 0 && qy == 0) begin
      rx = px; ry = py;
    end else if (px == qx && fadd(py, qy, p) == 0) begin
      rx = 0; ry = 0;
    end else begin
      if (px == qx && py == qy)
        lam = fmul(fadd(fmul(3, fmul(px, px, p), p), a, p), finv(fmul(2, py, p), p), p);
      else
        lam = fmul(fsub(qy, py, p), finv(fsub(qx, px, p), p), p);
      rx = fsub(fsub(fmul(lam, lam, p), px, p), qx, p);
      ry = fsub(fmul(lam, fsub(px, rx, p), p), py, p);
    end
  endtask

  function automatic big_t rnd(input big_t p);
    big_t r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r % p;
  endfunction

  // mode 0: addition, 1: doubling, 2: inverse pair, 3: P at infinity
  task automatic gen(input big_t p, input int mode,
                     output big_t px, output big_t py, output big_t qx, output big_t qy);
    px = rnd(p); py = rnd(p); qx = rnd(p); qy = rnd(p);
    case (mode)
      0: if (qx == px) qx = (px + 1) % p;
      1: begin if (py == 0) py = 1; qx = px; qy = py; end
      2: begin qx = px; qy = (p - py) % p; end
      default: begin px = 0; py = 0; end
    endcase
  endtask

  task automatic run8(input big_t px, input big_t py, input big_t qx, input big_t qy,
                      output big_t rx, output big_t ry, output int lat);
    @(negedge clk);
    if8.Px = px[7:0]; if8.Py = py[7:0]; if8.Qx = qx[7:0]; if8.Qy = qy[7:0];
    if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    lat = 1;
    while (!if8.out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("done8", big_t'(if8.out_valid), 1);
    rx = big_t'(if8.Rx);
    ry = big_t'(if8.Ry);
    @(negedge clk);
    check("pulse8", big_t'(if8.out_valid), 0);
  endtask

  task automatic run128(input big_t px, input big_t py, input big_t qx, input big_t qy,
                        output big_t rx, output big_t ry, output int lat);
    @(negedge clk);
    if128.Px = px[127:0]; if128.Py = py[127:0]; if128.Qx = qx[127:0]; if128.Qy = qy[127:0];
    if128.in_valid = 1'b1;
    @(negedge clk);
    if128.in_valid = 1'b0;
    lat = 1;
    while (!if128.out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("done128", big_t'(if128.out_valid), 1);
    rx = big_t'(if128.Rx);
    ry = big_t'(if128.Ry);
    @(negedge clk);
    check("pulse128", big_t'(if128.out_valid), 0);
  endtask

  typedef struct {
    big_t px, py, qx, qy, ex, ey;
    int   lat;
  } vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    big_t px, py, qx, qy, rx, ry, ex, ey, hx, hy;
    int   lat, wait_n;
    logic seen;

    if8.Px = '0; if8.Py = '0; if8.Qx = '0; if8.Qy = '0; if8.in_valid = 1'b0;
    if128.Px = '0; if128.Py = '0; if128.Qx = '0; if128.Qy = '0; if128.in_valid = 1'b0;

    tbl[0] = '{3, 6, 3, 6, 80, 10, -1};
    tbl[1] = '{3, 6, 80, 10, 80, 87, -1};
    tbl[2] = '{80, 10, 80, 87, 0, 0, 3};
    tbl[3] = '{0, 0, 3, 6, 3, 6, 3};
    tbl[4] = '{3, 6, 0, 0, 3, 6, 3};
    tbl[5] = '{80, 10, 80, 10, 3, 91, -1};
    tbl[6] = '{80, 87, 3, 6, 3, 91, -1};
    tbl[7] = '{3, 91, 3, 6, 0, 0, 3};

    repeat (3) @(negedge clk);
    check("rst_ov8", big_t'(if8.out_valid), 0);
    check("rst_rx8", big_t'(if8.Rx), 0);
    check("rst_ry8", big_t'(if8.Ry), 0);
    check("rst_ov128", big_t'(if128.out_valid), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(tbl[i].px, tbl[i].py, tbl[i].qx, tbl[i].qy, rx, ry, lat);
      check($sformatf("tbl%0d_rx", i), rx, tbl[i].ex);
      check($sformatf("tbl%0d_ry", i), ry, tbl[i].ey);
      if (tbl[i].lat >= 0) check($sformatf("tbl%0d_lat", i), big_t'(lat), big_t'(tbl[i].lat));
    end

    // Result holds with no further pulses while idle.
    run8(3, 6, 3, 6, rx, ry, lat);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (if8.out_valid) seen = 1'b1;
    end
    check("hold_ov", big_t'(seen), 0);
    check("hold_rx", big_t'(if8.Rx), 80);
    check("hold_ry", big_t'(if8.Ry), 10);

    // A request arriving mid-operation is dropped, not queued.
    @(negedge clk);
    if8.Px = 8'd3; if8.Py = 8'd6; if8.Qx = 8'd80; if8.Qy = 8'd10; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    if8.Px = 8'd3; if8.Py = 8'd6; if8.Qx = 8'd3; if8.Qy = 8'd6; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    wait_n = 0;
    while (!if8.out_valid && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("midop_done", big_t'(if8.out_valid), 1);
    check("midop_rx", big_t'(if8.Rx), 80);
    check("midop_ry", big_t'(if8.Ry), 87);
    @(negedge clk);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (if8.out_valid) seen = 1'b1;
    end
    check("midop_noqueue", big_t'(seen), 0);

    // Reset while the doubling is inverting: no pulse, outputs cleared.
    @(negedge clk);
    if8.Px = 8'd3; if8.Py = 8'd6; if8.Qx = 8'd3; if8.Qy = 8'd6; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if8.out_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (if8.out_valid) seen = 1'b1;
    end
    check("rstmid_ov", big_t'(seen), 0);
    check("rstmid_rx", big_t'(if8.Rx), 0);
    check("rstmid_ry", big_t'(if8.Ry), 0);
    run8(3, 6, 80, 10, rx, ry, lat);
    check("post_rst_rx", rx, 80);
    check("post_rst_ry", ry, 87);

    for (int i = 0; i < 24; i++) begin
      gen(P8, i % 4, px, py, qx, qy);
      ref_add(px, py, qx, qy, P8, A8, ex, ey);
      run8(px, py, qx, qy, rx, ry, lat);
      check($sformatf("rnd8_%0d_rx", i), rx, ex);
      check($sformatf("rnd8_%0d_ry", i), ry, ey);
    end

    hx = 0;
    hy = 0;
    for (int i = 0; i < 10; i++) begin
      gen(P128, (i < 2) ? 0 : (i % 4), px, py, qx, qy);
      ref_add(px, py, qx, qy, P128, A128, ex, ey);
      run128(px, py, qx, qy, rx, ry, lat);
      check($sformatf("rnd128_%0d_rx", i), rx, ex);
      check($sformatf("rnd128_%0d_ry", i), ry, ey);
      check($sformatf("rnd128_%0d_lat_le820", i), big_t'(lat <= 820), 1);
      if ((i % 4) >= 2) check($sformatf("rnd128_%0d_lat3", i), big_t'(lat), 3);
      hx = rx;
      hy = ry;
    end
    repeat (5) @(negedge clk);
    check("hold128_rx", big_t'(if128.Rx), hx);
    check("hold128_ry", big_t'(if128.Ry), hy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
